// File: rtl/sdram_responder_pkg.sv
// Shared constants, responder FSM state encodings and request decode helper
// for the SDRAM master-port responder.
package sdram_responder_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int RAM_ADR_W_DEF  = 12;

   typedef enum logic [1:0] {
      RSP_IDLE  = 2'd0,
      RSP_WAIT  = 2'd1,
      RSP_GRANT = 2'd2
   } rsp_state_t;

   // A request needs chipselect and exactly one strobe low.
   function automatic logic req_valid(input logic cs, input logic re_n, input logic we_n);
      return cs & (re_n ^ we_n);
   endfunction

endpackage

// File: rtl/sdram_responder_onchip_ram_sp.sv
// Single-port synchronous RAM: one write or read per cycle, one-cycle registered
// read; the read register holds its value on cycles without a read.
module onchip_ram_sp #(
   parameter  int DATA_WIDTH = 16,
   parameter  int DEPTH      = 1024,
   localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [AW-1:0]         addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/sdram_responder.sv
// On-chip stand-in for external SDRAM: strobe/chipselect request decode, wait-state
// FSM driving SDRAM_WAIT, single-port RAM and a valid/data read-latency pipe.
module sdram_responder
   import sdram_responder_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int ADDR_W       = RAM_ADR_W_DEF,
   parameter int DEPTH        = 1024,
   parameter int WAIT_CYCLES  = 2,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sdram_chipselect,
   input  logic                  sdram_re_n,
   input  logic                  sdram_we_n,
   input  logic [ADDR_W-1:0]     sdram_addr,
   input  logic [DATA_WIDTH-1:0] sdram_writedata,
   output logic                  SDRAM_WAIT,
   output logic [DATA_WIDTH-1:0] sdram_readdata,
   output logic                  sdram_readdatavalid,
   output logic                  err_both,
   output logic [15:0]           rd_count,
   output logic [15:0]           wr_count
);

   localparam int         RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   rsp_state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic req_ok, both_low, in_range, grant, wr_fire, rd_fire;
   logic vld0_q, rd_ok_q;
   logic [DATA_WIDTH-1:0] ram_q, dat0;

   assign req_ok   = req_valid(sdram_chipselect, sdram_re_n, sdram_we_n);
   assign both_low = sdram_chipselect & ~sdram_re_n & ~sdram_we_n;
   assign in_range = {1'b0, sdram_addr} < (ADDR_W + 1)'(DEPTH);
   assign grant    = (state_q == RSP_GRANT) && req_ok;
   assign wr_fire  = grant & ~sdram_we_n;
   assign rd_fire  = grant & ~sdram_re_n;

   // Counter is loaded with WAIT_CYCLES-1 so WAIT lasts exactly WAIT_CYCLES cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RSP_IDLE: begin
            if (req_ok) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = RSP_GRANT;
               end else begin
                  state_d = RSP_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         RSP_WAIT: begin
            if (!req_ok) begin
               state_d = RSP_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = RSP_GRANT;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RSP_GRANT: state_d = RSP_IDLE;
         default:   state_d = RSP_IDLE;
      endcase
   end

   // SDRAM_WAIT is registered from the next state, so it only depends on flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RSP_IDLE;
         cnt_q      <= 4'd0;
         SDRAM_WAIT <= 1'b1;
         err_both   <= 1'b0;
         rd_count   <= 16'd0;
         wr_count   <= 16'd0;
         vld0_q     <= 1'b0;
         rd_ok_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         SDRAM_WAIT <= (state_d != RSP_GRANT);
         vld0_q     <= rd_fire;
         if (both_low) begin
            err_both <= 1'b1;
         end
         if (wr_fire) begin
            wr_count <= wr_count + 16'd1;
         end
         if (rd_fire) begin
            rd_count <= rd_count + 16'd1;
            rd_ok_q  <= in_range;
         end
      end
   end

   onchip_ram_sp #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_fire & in_range),
      .re    (rd_fire & in_range),
      .addr  (sdram_addr[RAM_AW-1:0]),
      .wdata (sdram_writedata),
      .rdata (ram_q)
   );

   // Out-of-range reads and the post-reset state both present zero.
   assign dat0 = rd_ok_q ? ram_q : '0;

   generate
      if (READ_LATENCY == 1) begin : g_direct
         assign sdram_readdatavalid = vld0_q;
         assign sdram_readdata      = dat0;
      end else begin : g_pipe
         logic [READ_LATENCY-2:0] vld_sr;
         logic [DATA_WIDTH-1:0]   dat_sr [READ_LATENCY-1];

         always_ff @(posedge clk) begin
            if (reset) begin
               vld_sr <= '0;
               for (int i = 0; i < READ_LATENCY - 1; i++) begin
                  dat_sr[i] <= '0;
               end
            end else begin
               vld_sr[0] <= vld0_q;
               if (vld0_q) begin
                  dat_sr[0] <= dat0;
               end
               for (int i = 1; i < READ_LATENCY - 1; i++) begin
                  vld_sr[i] <= vld_sr[i-1];
                  if (vld_sr[i-1]) begin
                     dat_sr[i] <= dat_sr[i-1];
                  end
               end
            end
         end

         assign sdram_readdatavalid = vld_sr[READ_LATENCY-2];
         assign sdram_readdata      = dat_sr[READ_LATENCY-2];
      end
   endgenerate

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: two instances (2 wait states / latency 2 and
// 0 wait states / latency 3) driven in turn, reads scored against a queue.
module tb_sdram_responder;
   import sdram_responder_pkg::*;

   localparam int DW    = 16;
   localparam int AW    = 12;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          cs_a, cs_b, re_n, we_n;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;

   logic          wait_a, rdv_a, err_a, wait_b, rdv_b, err_b;
   logic [DW-1:0] rdata_a, rdata_b;
   logic [15:0]   rdc_a, wrc_a, rdc_b, wrc_b;

   sdram_responder #(
      .DATA_WIDTH(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(2), .READ_LATENCY(2)
   ) dut_a (
      .clk(clk), .reset(reset), .sdram_chipselect(cs_a), .sdram_re_n(re_n),
      .sdram_we_n(we_n), .sdram_addr(addr), .sdram_writedata(wdata),
      .SDRAM_WAIT(wait_a), .sdram_readdata(rdata_a), .sdram_readdatavalid(rdv_a),
      .err_both(err_a), .rd_count(rdc_a), .wr_count(wrc_a)
   );

   sdram_responder #(
      .DATA_WIDTH(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(0), .READ_LATENCY(3)
   ) dut_b (
      .clk(clk), .reset(reset), .sdram_chipselect(cs_b), .sdram_re_n(re_n),
      .sdram_we_n(we_n), .sdram_addr(addr), .sdram_writedata(wdata),
      .SDRAM_WAIT(wait_b), .sdram_readdata(rdata_b), .sdram_readdatavalid(rdv_b),
      .err_both(err_b), .rd_count(rdc_b), .wr_count(wrc_b)
   );

   typedef struct {
      logic [DW-1:0] dat;
      int            due;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_err  = 0;
   bit   sel    = 1'b0;

   logic          wait_sel;
   logic [DW-1:0] rdata_sel;
   assign wait_sel  = sel ? wait_b : wait_a;
   assign rdata_sel = sel ? rdata_b : rdata_a;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called #1 after a rising edge; holds the request until SDRAM_WAIT drops.
   task automatic do_req(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] exp_rd, input bit push, output int g);
      int t, wc, rl;
      bit got;
      wc  = sel ? 0 : 2;
      rl  = sel ? 3 : 2;
      t   = cyc;
      g   = -1;
      got = 1'b0;
      if (sel) cs_b = 1'b1;
      else     cs_a = 1'b1;
      re_n  = is_wr;
      we_n  = !is_wr;
      addr  = a;
      wdata = wd;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (!wait_sel) begin
            got = 1'b1;
            g   = cyc;
         end
      end
      if (!got) begin
         check("accept_timeout", 1, 0);
      end else begin
         if (is_wr) check("wr_accept_lat", g - t, 1 + wc);
         else       check("rd_accept_lat", g - t, 1 + wc);
         if (!is_wr && push) exp_q.push_back('{exp_rd, g + rl});
      end
      @(posedge clk);
      #1;
      cs_a = 1'b0;
      cs_b = 1'b0;
      re_n = 1'b1;
      we_n = 1'b1;
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (rdv_a || rdv_b) begin
         if ((sel && rdv_a) || (!sel && rdv_b)) begin
            check("stray_vld", 1, 0);
         end else if (exp_q.size() == 0) begin
            check("unexpected_vld", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("rd_data", rdata_sel, e.dat);
            check("rd_cycle", cyc, e.due);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int  g, prev_g;
      bit  saw_grant;
      reset = 1'b1;
      cs_a  = 1'b0;
      cs_b  = 1'b0;
      re_n  = 1'b1;
      we_n  = 1'b1;
      addr  = '0;
      wdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      check("rst_wait_a", wait_a, 1);
      check("rst_rdv_a", rdv_a, 0);
      check("rst_rdata_a", rdata_a, 0);
      check("rst_rdc_a", rdc_a, 0);
      check("rst_wrc_a", wrc_a, 0);
      check("rst_err_a", err_a, 0);
      check("rst_wait_b", wait_b, 1);
      @(posedge clk);
      #1;

      // Two wait states: write then read back.
      sel = 1'b0;
      do_req(1'b1, 12'd5, 16'h00AB, 16'h0, 1'b0, g);
      do_req(1'b0, 12'd5, 16'h0, 16'h00AB, 1'b1, g);
      idle(4);
      check("basic_wrc", wrc_a, 1);
      check("basic_rdc", rdc_a, 1);

      // Out-of-range write must not alias onto addr 0.
      do_req(1'b1, 12'd0, 16'h1234, 16'h0, 1'b0, g);
      do_req(1'b1, 12'(DEPTH), 16'hFFFF, 16'h0, 1'b0, g);
      do_req(1'b0, 12'(DEPTH), 16'h0, 16'h0000, 1'b1, g);
      do_req(1'b0, 12'd0, 16'h0, 16'h1234, 1'b1, g);
      idle(4);
      check("oor_wrc", wrc_a, 3);
      check("oor_rdc", rdc_a, 3);

      // Both strobes low: flag only.
      cs_a = 1'b1;
      re_n = 1'b0;
      we_n = 1'b0;
      addr = 12'd5;
      repeat (3) begin
         @(negedge clk);
         check("both_low_wait", wait_a, 1);
      end
      @(posedge clk);
      #1;
      cs_a = 1'b0;
      re_n = 1'b1;
      we_n = 1'b1;
      idle(3);
      check("both_err_a", err_a, 1);
      check("both_err_b", err_b, 0);
      check("both_wrc", wrc_a, 3);
      check("both_rdc", rdc_a, 3);

      // Chipselect dropped during WAIT.
      cs_a = 1'b1;
      re_n = 1'b0;
      addr = 12'd5;
      @(posedge clk);
      #1;
      cs_a = 1'b0;
      re_n = 1'b1;
      saw_grant = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (!wait_a) saw_grant = 1'b1;
      end
      check("abort_no_grant", saw_grant, 0);
      check("abort_rdc", rdc_a, 3);
      @(posedge clk);
      #1;

      // Zero wait states: preload 1..4, then four back-to-back reads.
      sel = 1'b1;
      for (int i = 0; i < 4; i++) do_req(1'b1, 12'(i), 16'(i + 1), 16'h0, 1'b0, g);
      prev_g = 0;
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, 12'(i), 16'h0, 16'(i + 1), 1'b1, g);
         if (i > 0) check("rd_spacing", g - prev_g, 2);
         prev_g = g;
      end
      idle(5);
      check("b2b_wrc", wrc_b, 4);
      check("b2b_rdc", rdc_b, 4);

      // Reset in cycle g+1 of a latency-3 read: the pulse must never appear.
      do_req(1'b0, 12'd1, 16'h0, 16'h0, 1'b0, g);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      idle(6);
      check("mid_rst_rdc", rdc_b, 0);
      check("mid_rst_wrc", wrc_b, 0);
      check("mid_rst_wait", wait_b, 1);
      check("mid_rst_rdata", rdata_b, 0);
      check("mid_rst_err_a", err_a, 0);
      do_req(1'b0, 12'd2, 16'h0, 16'h0003, 1'b1, g);
      do_req(1'b0, 12'd0, 16'h0, 16'h0001, 1'b1, g);
      idle(6);
      check("post_rst_rdc", rdc_b, 2);
      check("sb_drain", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
